// File: rtl/i2c_bert_pkg.sv
// Shared encodings for the I2C BERT sequencer: engine commands, pass status,
// FSM states and the PRBS8 feedback taps.
package i2c_bert_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_NACK  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Feedback taps for bits 7,5,4,3 of the shift-left Fibonacci PRBS8.
  localparam logic [7:0] PRBS8_TAPS  = 8'hB8;
  localparam logic [7:0] PRBS8_RESET = 8'h01;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_START = 4'd1,
    W_ADDR  = 4'd2,
    W_DATA  = 4'd3,
    W_STOP  = 4'd4,
    R_START = 4'd5,
    R_ADDR  = 4'd6,
    R_DATA  = 4'd7,
    R_STOP  = 4'd8,
    FIN     = 4'd9
  } bert_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bert_prbs8.sv
// Loadable PRBS8 generator; value is the byte currently presented, advance
// steps it to the next sequence element.
module bert_prbs8
  import i2c_bert_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  // Seed load takes priority over advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= PRBS8_RESET;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= {value[6:0], ^(value & PRBS8_TAPS)};
    end
  end

endmodule

// File: rtl/i2c_bert_sequencer.sv
// Sequences one BERT pass over a byte-level I2C master engine: write a PRBS8
// stream, read it back, count bit errors and NACKs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// W_START | START condition for the write phase
// W_ADDR  | address byte, write direction
// W_DATA  | PRBS data bytes written, len times
// W_STOP  | STOP after write phase (or after write-phase NACK / abort)
// R_START | START condition for the read phase
// R_ADDR  | address byte, read direction
// R_DATA  | bytes read and compared, NACK flagged on the last one
// R_STOP  | STOP after read phase
// FIN     | one-cycle done pulse, back to IDLE
//
// Every command state offers its command (cmd_valid) until accepted, then
// waits for the single response with pending set.
module i2c_bert_sequencer
  import i2c_bert_pkg::*;
#(
  parameter int ERR_W  = 16,
  parameter int NACK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [6:0]        cfg_addr,
  input  logic [7:0]        cfg_len,
  input  logic [7:0]        cfg_seed,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [7:0]        cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_ack,
  input  logic [7:0]        rsp_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [ERR_W-1:0]  bit_err_cnt,
  output logic [NACK_W-1:0] nack_cnt
);

  bert_state_t       state, state_nxt;
  logic              pending;
  logic              abort_req;
  logic              wr_nack;
  logic [8:0]        byte_cnt;
  logic [8:0]        len_q;
  logic [6:0]        addr_q;
  logic [7:0]        tx_byte, rx_byte;
  logic              start_go, hs, rsp_take, abort_eff, last_byte;
  logic              is_addr_wr, nack_seen;
  logic [8:0]        len_eff;
  logic [7:0]        seed_eff;
  logic [ERR_W:0]    err_sum;

  assign busy      = (state != IDLE) && (state != FIN);
  assign cmd_valid = busy && !pending;
  assign hs        = cmd_valid && cmd_ready;
  assign rsp_take  = pending && rsp_valid;
  assign start_go  = (state == IDLE) && start && !abort;
  assign abort_eff = abort_req || abort;
  assign last_byte = (byte_cnt == 9'd1);
  assign len_eff   = (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
  assign seed_eff  = (cfg_seed == 8'd0) ? PRBS8_RESET : cfg_seed;
  assign is_addr_wr = (state == W_ADDR) || (state == W_DATA) || (state == R_ADDR);
  assign nack_seen  = rsp_take && is_addr_wr && !rsp_ack;
  assign err_sum   = {1'b0, bit_err_cnt} + {{(ERR_W-3){1'b0}}, popcount8(rsp_data ^ rx_byte)};

  bert_prbs8 u_tx_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (start_go),
    .advance (rsp_take && (state == W_DATA)),
    .seed    (seed_eff),
    .value   (tx_byte)
  );

  bert_prbs8 u_rx_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (start_go),
    .advance (rsp_take && (state == R_DATA)),
    .seed    (seed_eff),
    .value   (rx_byte)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and command decode; a NACK or abort diverts to the phase STOP.
  always_comb begin
    state_nxt = state;
    cmd_op    = CMD_START;
    cmd_data  = 8'h00;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_nxt = W_START;
      end
      W_START: begin
        if (rsp_take) state_nxt = abort_eff ? W_STOP : W_ADDR;
      end
      W_ADDR: begin
        cmd_op   = CMD_WRITE;
        cmd_data = {addr_q, 1'b0};
        if (rsp_take) state_nxt = (!rsp_ack || abort_eff) ? W_STOP : W_DATA;
      end
      W_DATA: begin
        cmd_op   = CMD_WRITE;
        cmd_data = tx_byte;
        if (rsp_take && (!rsp_ack || abort_eff || last_byte)) state_nxt = W_STOP;
      end
      W_STOP: begin
        cmd_op = CMD_STOP;
        if (rsp_take) state_nxt = (wr_nack || abort_eff) ? FIN : R_START;
      end
      R_START: begin
        if (rsp_take) state_nxt = abort_eff ? R_STOP : R_ADDR;
      end
      R_ADDR: begin
        cmd_op   = CMD_WRITE;
        cmd_data = {addr_q, 1'b1};
        if (rsp_take) state_nxt = (!rsp_ack || abort_eff) ? R_STOP : R_DATA;
      end
      R_DATA: begin
        cmd_op   = CMD_READ;
        cmd_data = {7'b0000000, last_byte};
        if (rsp_take && (abort_eff || last_byte)) state_nxt = R_STOP;
      end
      R_STOP: begin
        cmd_op = CMD_STOP;
        if (rsp_take) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake tracking, configuration, byte counter, error/NACK accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      abort_req   <= 1'b0;
      wr_nack     <= 1'b0;
      byte_cnt    <= 9'd0;
      len_q       <= 9'd0;
      addr_q      <= 7'd0;
      status      <= ST_OK;
      bit_err_cnt <= '0;
      nack_cnt    <= '0;
    end else if (start_go) begin
      pending     <= 1'b0;
      abort_req   <= 1'b0;
      wr_nack     <= 1'b0;
      byte_cnt    <= len_eff;
      len_q       <= len_eff;
      addr_q      <= cfg_addr;
      status      <= ST_OK;
      bit_err_cnt <= '0;
      nack_cnt    <= '0;
    end else begin
      if (hs) begin
        pending <= 1'b1;
      end else if (rsp_take) begin
        pending <= 1'b0;
      end

      if (nack_seen) begin
        if (nack_cnt != {NACK_W{1'b1}}) nack_cnt <= nack_cnt + {{(NACK_W-1){1'b0}}, 1'b1};
        if (status != ST_ABORT) status <= ST_NACK;
        if (state != R_ADDR) wr_nack <= 1'b1;
      end

      // Abort overrides any NACK status set in the same cycle.
      if (busy && abort) begin
        abort_req <= 1'b1;
        status    <= ST_ABORT;
      end

      if (rsp_take && (state == W_DATA)) begin
        byte_cnt <= byte_cnt - 9'd1;
      end
      if (rsp_take && (state == W_STOP)) begin
        byte_cnt <= len_q;
      end
      if (rsp_take && (state == R_DATA)) begin
        byte_cnt    <= byte_cnt - 9'd1;
        bit_err_cnt <= err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_i2c_bert_sequencer.sv
// Self-checking bench: a behavioural I2C engine/target model answers commands
// with random latency, and the expected command stream and counters are
// derived from the PRBS8 rule and the pass configuration.
module tb_i2c_bert_sequencer;
  import i2c_bert_pkg::*;

  localparam int ERR_W  = 16;
  localparam int NACK_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [6:0]        cfg_addr;
  logic [7:0]        cfg_len, cfg_seed;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_data;
  logic              rsp_valid, rsp_ack;
  logic [7:0]        rsp_data;
  logic              busy, done;
  logic [1:0]        status;
  logic [ERR_W-1:0]  bit_err_cnt;
  logic [NACK_W-1:0] nack_cnt;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [7:0] flip[256];

  always #5 clk = ~clk;

  i2c_bert_sequencer #(.ERR_W(ERR_W), .NACK_W(NACK_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .busy(busy), .done(done), .status(status),
    .bit_err_cnt(bit_err_cnt), .nack_cnt(nack_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PRBS8 step: shift left, new bit is the parity of bits 7,5,4,3.
  function automatic logic [7:0] prbs_next(input logic [7:0] v);
    logic fb;
    fb = (($countones(v & 8'hB8) % 2) == 1);
    return {v[6:0], fb};
  endfunction

  task automatic build_expected(input logic [6:0] a, input int n, input logic [7:0] sd,
                                input bit nack_m, input bit abort_m);
    logic [7:0] l;
    exp_q.delete();
    l = (sd == 8'h00) ? 8'h01 : sd;
    exp_q.push_back({CMD_START, 8'h00});
    exp_q.push_back({CMD_WRITE, a, 1'b0});
    if (nack_m) begin
      exp_q.push_back({CMD_STOP, 8'h00});
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({CMD_WRITE, l});
      l = prbs_next(l);
      if (abort_m && i == 1) begin
        exp_q.push_back({CMD_STOP, 8'h00});
        return;
      end
    end
    exp_q.push_back({CMD_STOP, 8'h00});
    exp_q.push_back({CMD_START, 8'h00});
    exp_q.push_back({CMD_WRITE, a, 1'b1});
    for (int i = 0; i < n; i++) exp_q.push_back({CMD_READ, 7'd0, (i == n - 1)});
    exp_q.push_back({CMD_STOP, 8'h00});
  endtask

  task automatic run_pass(input string nm, input logic [6:0] a, input logic [7:0] len,
                          input logic [7:0] sd, input bit nack_m, input bit abort_m,
                          input int hold, input bit rst_m, input bit poke_start);
    int n, cyc, delay, hold_left, rd_idx, n_wdata, n_reads, n_done, exp_err;
    bit outstanding, finished, expect_addr, rd_dir;
    logic [1:0] last_op;
    logic [7:0] last_data;
    logic [7:0] mem[$];

    n = (len == 8'd0) ? 256 : int'(len);
    build_expected(a, n, sd, nack_m, abort_m);
    exp_err = 0;
    if (!nack_m && !abort_m) for (int i = 0; i < n; i++) exp_err += $countones(flip[i]);
    got_q.delete();
    outstanding = 0; finished = 0; expect_addr = 0; rd_dir = 0;
    delay = 0; rd_idx = 0; n_wdata = 0; n_reads = 0; n_done = 0; hold_left = hold;
    last_op = CMD_START; last_data = 8'h00;

    @(negedge clk);
    cfg_addr = a; cfg_len = len; cfg_seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!finished && cyc < 8000) begin
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_data = 8'h00;
      start = poke_start && busy && ($urandom_range(0, 7) == 0);
      if (done) begin
        n_done++;
        finished = 1;
        abort = 1'b0;
      end else if (outstanding) begin
        if (abort_m && n_wdata >= 2) abort = 1'b1;
        if (rst_m && n_reads == 2) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk({nm, "_rst_valid"}, cmd_valid, 0);
          chk({nm, "_rst_busy"}, busy, 0);
          chk({nm, "_rst_err"}, bit_err_cnt, 0);
          chk({nm, "_rst_nack"}, nack_cnt, 0);
          chk({nm, "_rst_status"}, status, ST_OK);
          return;
        end
        if (delay == 0) begin
          rsp_valid = 1'b1;
          outstanding = 0;
          rsp_ack = 1'($urandom);
          if (last_op == CMD_START) begin
            expect_addr = 1;
          end else if (last_op == CMD_WRITE) begin
            if (expect_addr) begin
              expect_addr = 0;
              rd_dir = last_data[0];
              rsp_ack = !nack_m;
            end else begin
              rsp_ack = 1'b1;
              if (!rd_dir) mem.push_back(last_data);
            end
          end else if (last_op == CMD_READ) begin
            rsp_data = (rd_idx < mem.size()) ? (mem[rd_idx] ^ flip[rd_idx]) : 8'h00;
            rd_idx++;
          end
        end else begin
          delay--;
        end
      end else if (cmd_valid) begin
        if (hold_left > 0) begin
          chk({nm, "_hold_op"}, cmd_op, exp_q[0][9:8]);
          chk({nm, "_hold_data"}, cmd_data, exp_q[0][7:0]);
          hold_left--;
        end else begin
          cmd_ready = 1'b1;
          got_q.push_back({cmd_op, cmd_data});
          outstanding = 1;
          last_op = cmd_op;
          last_data = cmd_data;
          delay = $urandom_range(0, 2);
          if (cmd_op == CMD_WRITE && !expect_addr && !rd_dir) n_wdata++;
          if (cmd_op == CMD_READ) n_reads++;
          if (abort_m && n_wdata == 2) delay = 2;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; abort = 1'b0;
    chk({nm, "_done_seen"}, finished, 1);
    for (int k = 0; k < 3; k++) begin
      if (done) n_done++;
      chk({nm, "_idle_busy"}, busy, 0);
      @(negedge clk);
    end
    chk({nm, "_done_pulses"}, n_done, 1);
    chk({nm, "_cmd_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_cmd%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, "_bit_err"}, bit_err_cnt, exp_err);
    chk({nm, "_nack"}, nack_cnt, nack_m ? 1 : 0);
    chk({nm, "_status"}, status, abort_m ? ST_ABORT : (nack_m ? ST_NACK : ST_OK));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_addr = 7'd0; cfg_len = 8'd0; cfg_seed = 8'd0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0; rsp_data = 8'h00;
    for (int i = 0; i < 256; i++) flip[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_status", status, 0);
    chk("rst_err", bit_err_cnt, 0);
    chk("rst_nack", nack_cnt, 0);
    rst = 1'b0;

    // Loopback pass, ready held off for 5 cycles on the first command.
    run_pass("basic", 7'h3C, 8'd4, 8'hA5, 0, 0, 5, 0, 0);
    if (got_q.size() >= 6) begin
      chk("basic_addr", got_q[1][7:0], 8'h78);
      chk("basic_d0", got_q[2][7:0], 8'hA5);
      chk("basic_d1", got_q[3][7:0], 8'h4A);
      chk("basic_d2", got_q[4][7:0], 8'h95);
      chk("basic_d3", got_q[5][7:0], 8'h2A);
    end

    flip[1] = 8'h81;
    run_pass("flip", 7'h3C, 8'd4, 8'hA5, 0, 0, 0, 0, 0);
    flip[1] = 8'h00;

    run_pass("nack", 7'h50, 8'd4, 8'hA5, 1, 0, 0, 0, 0);
    run_pass("abort", 7'h21, 8'd6, 8'h5A, 0, 1, 0, 0, 0);
    run_pass("len256", 7'h11, 8'd0, 8'h00, 0, 0, 0, 0, 0);
    if (got_q.size() > 2) chk("len256_first", got_q[2][7:0], 8'h01);

    // Start together with abort in IDLE must not begin a pass.
    @(negedge clk);
    cfg_len = 8'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", busy, 0);
    chk("startabort_valid", cmd_valid, 0);
    @(negedge clk);
    chk("startabort_busy2", busy, 0);
    chk("startabort_status", status, ST_OK);

    run_pass("midrst", 7'h2B, 8'd6, 8'h33, 0, 0, 0, 1, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) flip[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      run_pass($sformatf("rand%0d", r), 7'($urandom), 8'($urandom_range(1, 20)),
               8'($urandom), 0, 0, $urandom_range(0, 3), 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_bert_sequencer.md
Name: i2c_bert_sequencer

Overview:
Controller that sequences one I2C bit-error-rate test pass over a byte-level I2C master engine inside the tt05 I2C BERT design. It writes a PRBS8 byte stream to a target address, reads the same number of bytes back, and compares them against a regenerated PRBS8 stream. It accumulates bit-error and NACK counts and reports pass status. It issues exactly one command at a time to the engine over a valid/ready command channel and waits for a single response pulse per command.

Parameters:
ERR_W, 16, width of the saturating bit-error counter
NACK_W, 8, width of the saturating NACK counter

Ports:
clk  in  1  system clock; every flop is on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that begins a test pass; ignored while busy
abort  in  1  level signal; requests an orderly abort
cfg_addr  in  7  7-bit target address; latched on start
cfg_len  in  8  byte count; 0 means 256; latched on start
cfg_seed  in  8  PRBS seed; 0 is replaced by 0x01; latched on start
cmd_valid  out  1  command offered to the engine
cmd_ready  in  1  engine accepts the command
cmd_op  out  2  command: 0 START, 1 STOP, 2 WRITE, 3 READ
cmd_data  out  8  WRITE byte; for READ, bit0=1 means NACK this byte (last byte)
rsp_valid  in  1  one-cycle response pulse, one per accepted command
rsp_ack  in  1  target ACKed the WRITE; don't-care for other ops
rsp_data  in  8  byte received by READ
busy  out  1  pass in progress
done  out  1  one-cycle pulse at the end of a pass
status  out  2  0 OK, 1 NACK, 2 ABORT; held until next start
bit_err_cnt  out  ERR_W  accumulated bit errors
nack_cnt  out  NACK_W  accumulated NACKs

Behaviour:
- Reset: FSM goes to IDLE. cmd_valid, busy and done are 0. cmd_op, cmd_data, status, bit_err_cnt and nack_cnt are all 0. Both LFSRs are loaded with 0x01.
- States: IDLE, W_START, W_ADDR, W_DATA, W_STOP, R_START, R_ADDR, R_DATA, R_STOP, FIN.
- Each command state:
  - Drive cmd_valid=1 with stable op and data until the cmd_valid&cmd_ready cycle.
  - Then drop cmd_valid and wait for rsp_valid.
  - Move on in the cycle after rsp_valid.
  - There is never more than one outstanding command.
- Start: a start pulse in IDLE at cycle n does the following.
  - Latches the configuration.
  - Clears the counters and status.
  - Loads both LFSRs with the seed.
  - Sets busy. At cycle n+1: cmd_valid=1, cmd_op=START.
- Sequence:
  - W_START, then W_ADDR (WRITE {addr,0}), then W_DATA ×len (WRITE txLFSR), then W_STOP.
  - Then R_START, then R_ADDR (WRITE {addr,1}), then R_DATA ×len (READ; bit0=1 only on the last byte), then R_STOP.
  - Then FIN.
- PRBS8 (Fibonacci):
  - next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
  - The transmitted byte is the current value; the LFSR advances after each WRITE response.
  - The receive LFSR advances after each READ response.
- Compare: on a READ response, bit_err_cnt += popcount(rsp_data ^ rxLFSR), saturating at all-ones.
- NACK: rsp_ack=0 on an address or data WRITE does three things.
  - nack_cnt increments (saturating) and status becomes 1.
  - The current phase jumps to its STOP.
  - After W_STOP, the read phase is skipped and the FSM goes to FIN.
- Byte counter: 9-bit down-count loaded with (cfg_len==0 ? 256 : cfg_len). Leave the data state when the count reaches 0.
- Abort: when sampled high in any busy state:
  - If a command is outstanding or offered, complete its handshake and response.
  - Then issue STOP if the bus is inside START..STOP, then go to FIN.
  - Set status=2; ABORT overrides NACK.
  - Abort in IDLE is ignored. Start and abort in the same IDLE cycle: abort wins and no pass starts.
- FIN: done=1 for one cycle, busy=0, return to IDLE. The counters and status hold.
- start while busy: ignored.
- rsp_valid while no command is outstanding: ignored.
- rst mid-pass: immediate return to reset values. No STOP is issued; bus recovery belongs to the engine's own reset.

Decomposition:
- Shared package i2c_bert_pkg holds:
  - the cmd_op encodings (CMD_START, CMD_STOP, CMD_WRITE, CMD_READ);
  - the status codes (ST_OK, ST_NACK, ST_ABORT);
  - the FSM state enum;
  - the PRBS8 tap constant.
- One sub-module, bert_prbs8, contains a load/advance LFSR. It is instantiated twice, for tx and rx.

Test Plan:
- Seed 0xA5, len 4, loopback target model. Required:
  - Command stream START, W 0x??(addr<<1), W A5, W 4A, W 95, W 2A, STOP, START, W (addr<<1|1), 4×READ (last bit0=1), STOP.
  - bit_err_cnt=0, status=0, one done pulse.
- Same pass with the model flipping bits 0 and 7 of read byte 2. Required: bit_err_cnt=2, status=0.
- Target NACKs the address (addr 0x50). Required: START, W 0xA0, STOP, done; nack_cnt=1, status=1; no read phase.
- Abort raised while the 2nd W_DATA is awaiting response. Required: that response completes, then STOP, then done with status=2.
- cfg_len=0, seed 0. Required: 256 writes with the first byte 0x01; 256 reads, with only the 256th READ carrying bit0=1.
- rst asserted mid-R_DATA. Required: next cycle cmd_valid=0, busy=0, counters=0; a subsequent start runs cleanly. Also start with cmd_ready tied low for 5 cycles: cmd_op and cmd_data stay stable.
